// File: rtl/ppu_pkg.sv
// Shared types and constants for the PPU CPU-side data port.
package ppu_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        VRD_WAIT  = 2'd1,
        PRD_WAIT  = 2'd2,
        PBUF_WAIT = 2'd3
    } ppu_state_e;

    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_ADDR   = 3'd6;
    localparam logic [2:0] REG_DATA   = 3'd7;
    localparam logic [5:0] PAL_HI     = 6'h3F;

    function automatic logic in_pal_space(input logic [5:0] addr_hi);
        return addr_hi == PAL_HI;
    endfunction

endpackage

// File: rtl/ppu_data_port.sv
// CPU access to PPU memory via $2006/$2007: owns v, t, w and the $2007 read buffer,
// and drives the VRAM and palette RAM CPU ports.
module ppu_data_port
    import ppu_pkg::*;
#(
    parameter int VRAM_AW = 14
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [2:0]         cpu_reg,
    input  logic [7:0]         cpu_wdata,
    input  logic               inc32,
    output logic [7:0]         cpu_rdata,
    output logic               cpu_ack,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic               vram_rden,
    output logic               vram_wren,
    output logic [7:0]         vram_wdata,
    input  logic [7:0]         vram_rdata,
    output logic [4:0]         pal_addr,
    output logic               pal_rden,
    output logic               pal_wren,
    output logic [7:0]         pal_wdata,
    input  logic [7:0]         pal_rdata
);

    localparam logic [VRAM_AW-1:0] ADDR_ONE  = {{(VRAM_AW-1){1'b0}}, 1'b1};
    // Palette reads refill the buffer from the nametable underneath ($3Fxx -> $2Fxx).
    localparam logic [VRAM_AW-1:0] PBUF_MASK = ~(ADDR_ONE << (VRAM_AW - 2));

    ppu_state_e state, state_nxt;

    logic [VRAM_AW-1:0] v;
    // The low byte of t is loaded straight into v, so only the high part is held.
    logic [VRAM_AW-9:0] t_hi;
    logic               w;
    logic [7:0]         rdbuf;

    logic               v_pal;
    logic               data_wr;
    logic               data_rd;
    logic               pal_rdata_unused;

    function automatic logic [VRAM_AW-1:0] step_v(input logic [VRAM_AW-1:0] a, input logic big);
        return a + (big ? VRAM_AW'(32) : VRAM_AW'(1));
    endfunction

    // Only the 6-bit colour index is returned to the CPU.
    assign pal_rdata_unused = ^pal_rdata[7:6];

    assign v_pal      = in_pal_space(v[VRAM_AW-1 -: 6]);
    assign data_wr    = cpu_req && (cpu_reg == REG_DATA) && cpu_we;
    assign data_rd    = cpu_req && (cpu_reg == REG_DATA) && !cpu_we;
    assign pal_addr   = v[4:0];
    assign vram_wdata = cpu_wdata;
    assign pal_wdata  = cpu_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vram_addr = v;
        vram_rden = 1'b0;
        vram_wren = 1'b0;
        pal_rden  = 1'b0;
        pal_wren  = 1'b0;
        case (state)
            IDLE: begin
                if (data_wr) begin
                    pal_wren  = v_pal;
                    vram_wren = !v_pal;
                end else if (data_rd) begin
                    pal_rden  = v_pal;
                    vram_rden = !v_pal;
                    state_nxt = v_pal ? PRD_WAIT : VRD_WAIT;
                end
            end
            VRD_WAIT: state_nxt = IDLE;
            PRD_WAIT: begin
                vram_addr = v & PBUF_MASK;
                vram_rden = 1'b1;
                state_nxt = PBUF_WAIT;
            end
            PBUF_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!reset_n) begin
            vram_rden = 1'b0;
            vram_wren = 1'b0;
            pal_rden  = 1'b0;
            pal_wren  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            v         <= '0;
            t_hi      <= '0;
            w         <= 1'b0;
            rdbuf     <= 8'h00;
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'h00;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req && !data_rd) begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= 8'h00;
                        if (data_wr) begin
                            v <= step_v(v, inc32);
                        end else if (cpu_reg == REG_STATUS && !cpu_we) begin
                            w <= 1'b0;
                        end else if (cpu_reg == REG_ADDR && cpu_we) begin
                            if (!w) begin
                                t_hi <= cpu_wdata[VRAM_AW-9:0];
                                w    <= 1'b1;
                            end else begin
                                v <= {t_hi, cpu_wdata};
                                w <= 1'b0;
                            end
                        end
                    end
                end
                VRD_WAIT: begin
                    cpu_rdata <= rdbuf;
                    rdbuf     <= vram_rdata;
                    cpu_ack   <= 1'b1;
                    v         <= step_v(v, inc32);
                end
                PRD_WAIT: begin
                    cpu_rdata <= {2'b00, pal_rdata[5:0]};
                end
                PBUF_WAIT: begin
                    rdbuf   <= vram_rdata;
                    cpu_ack <= 1'b1;
                    v       <= step_v(v, inc32);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_data_port.sv
// Bench for ppu_data_port: fixed vector table, hand sequences, then random accesses vs a model.
module tb_ppu_data_port;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [2:0]  cpu_reg = 3'd0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        inc32 = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [13:0] vram_addr;
    logic        vram_rden, vram_wren;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata = 8'h00;
    logic [4:0]  pal_addr;
    logic        pal_rden, pal_wren;
    logic [7:0]  pal_wdata;
    logic [7:0]  pal_rdata = 8'h00;

    ppu_data_port #(.VRAM_AW(14)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata), .inc32(inc32),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .vram_addr(vram_addr), .vram_rden(vram_rden), .vram_wren(vram_wren),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
        .pal_addr(pal_addr), .pal_rden(pal_rden), .pal_wren(pal_wren),
        .pal_wdata(pal_wdata), .pal_rdata(pal_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       we;
        bit [2:0] r;
        bit [7:0] d;
        bit       i32;
        int       lat;
        bit       rdchk;
        bit [7:0] rd;
        int       wk;   // 0 no write, 1 VRAM write, 2 palette write
        int       wa;
        bit [7:0] wd;
    } vec_t;

    int nchk = 0;
    int npass = 0;
    int seed = 0;

    function automatic bit [7:0] vinit(input int a);
        return 8'((a * 37) ^ (a >> 7) ^ seed);
    endfunction

    function automatic bit [7:0] pinit(input int a);
        return 8'((a * 29) + seed + 3);
    endfunction

    // Palette entries $10/$14/$18/$1C alias $00/$04/$08/$0C.
    function automatic int pidx(input int a);
        int i;
        i = a % 32;
        if (i >= 16 && i % 4 == 0) return i - 16;
        return i;
    endfunction

    // Memory models and strobe monitor
    bit [7:0] bvram [16384];
    bit [7:0] bpal  [32];
    logic fill_req = 1'b0, ld_req = 1'b0, ld_pal = 1'b0;
    int   ld_addr = 0;
    logic [7:0] ld_data = 8'h00;
    int ev_cnt = 0, ev_kind = 0, ev_addr = 0, ev_data = 0, multi_cnt = 0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 16384; i++) bvram[i] <= vinit(i);
            for (int i = 0; i < 32; i++) bpal[i] <= pinit(i);
        end else if (ld_req) begin
            if (ld_pal) bpal[ld_addr % 32] <= ld_data;
            else bvram[ld_addr % 16384] <= ld_data;
        end
        if (vram_wren) bvram[vram_addr] <= vram_wdata;
        if (vram_rden) vram_rdata <= bvram[vram_addr];
        if (pal_wren) bpal[pidx(int'(pal_addr))] <= pal_wdata;
        if (pal_rden) pal_rdata <= bpal[pidx(int'(pal_addr))];
        if (vram_wren) begin
            ev_cnt <= ev_cnt + 1; ev_kind <= 1; ev_addr <= int'(vram_addr); ev_data <= int'(vram_wdata);
        end else if (pal_wren) begin
            ev_cnt <= ev_cnt + 1; ev_kind <= 2; ev_addr <= int'(pal_addr); ev_data <= int'(pal_wdata);
        end
        if (int'(vram_rden) + int'(vram_wren) + int'(pal_rden) + int'(pal_wren) > 1)
            multi_cnt <= multi_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic vec_t mk(input bit we, input bit [2:0] r, input bit [7:0] d, input bit i32,
                                input int lat, input bit rdchk, input bit [7:0] rd,
                                input int wk, input int wa, input bit [7:0] wd);
        vec_t e;
        e.we = we; e.r = r; e.d = d; e.i32 = i32; e.lat = lat;
        e.rdchk = rdchk; e.rd = rd; e.wk = wk; e.wa = wa; e.wd = wd;
        return e;
    endfunction

    function automatic vec_t w6(input bit [7:0] d);
        return mk(1'b1, 3'd6, d, 1'b0, 1, 1'b0, 8'h00, 0, 0, 8'h00);
    endfunction

    task automatic fill_mem();
        @(negedge clk); fill_req = 1'b1;
        @(negedge clk); fill_req = 1'b0;
    endtask

    task automatic load(input bit pal, input int a, input bit [7:0] d);
        @(negedge clk); ld_req = 1'b1; ld_pal = pal; ld_addr = a; ld_data = d;
        @(negedge clk); ld_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0; cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge where ack was seen (lat 0 = no ack).
    task automatic access(input bit we, input bit [2:0] r, input bit [7:0] d, input bit i32,
                          output int lat, output bit [7:0] rd);
        cpu_req = 1'b1; cpu_we = we; cpu_reg = r; cpu_wdata = d; inc32 = i32;
        @(negedge clk);
        cpu_req = 1'b0;
        lat = 0; rd = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            if (cpu_ack) begin
                lat = k; rd = cpu_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t e, input string tag);
        int c0, lat;
        bit [7:0] rd;
        c0 = ev_cnt;
        access(e.we, e.r, e.d, e.i32, lat, rd);
        chk({tag, "_lat"}, lat, e.lat);
        if (e.rdchk) chk({tag, "_rdata"}, int'(rd), int'(e.rd));
        chk({tag, "_nwr"}, ev_cnt - c0, int'(e.wk != 0));
        if (e.wk != 0 && ev_cnt != c0) begin
            chk({tag, "_wkind"}, ev_kind, e.wk);
            chk({tag, "_waddr"}, ev_addr, e.wa);
            chk({tag, "_wdata"}, ev_data, int'(e.wd));
        end
    endtask

    // Reference model state
    int m_v, m_thi, m_w, m_rb;
    bit [7:0] mv [int];
    bit [7:0] mp [int];

    function automatic bit [7:0] rdv(input int a);
        return mv.exists(a) ? mv[a] : vinit(a);
    endfunction

    function automatic bit [7:0] rdp(input int i);
        return mp.exists(i) ? mp[i] : pinit(i);
    endfunction

    task automatic predict(input bit we, input bit [2:0] r, input bit [7:0] d, input bit i32,
                           output vec_t e);
        int inc;
        bit pal;
        e = mk(we, r, d, i32, 1, 1'b0, 8'h00, 0, 0, 8'h00);
        inc = i32 ? 32 : 1;
        pal = (m_v / 256) == 'h3F;
        if (r == 3'd2 && !we) begin
            m_w = 0; e.rdchk = 1'b1;
        end else if (r == 3'd6 && we) begin
            if (m_w == 0) begin m_thi = d % 64; m_w = 1; end
            else begin m_v = m_thi * 256 + d; m_w = 0; end
        end else if (r == 3'd7 && we) begin
            if (pal) begin mp[pidx(m_v)] = d; e.wk = 2; e.wa = m_v % 32; end
            else begin mv[m_v] = d; e.wk = 1; e.wa = m_v; end
            e.wd = d;
            m_v = (m_v + inc) % 16384;
        end else if (r == 3'd7) begin
            e.rdchk = 1'b1;
            if (pal) begin
                e.rd = rdp(pidx(m_v)) % 64;
                m_rb = rdv(m_v - 'h1000);   // buffer refills from the nametable under the palette
                e.lat = 3;
            end else begin
                e.rd = 8'(m_rb);
                m_rb = rdv(m_v);
                e.lat = 2;
            end
            m_v = (m_v + inc) % 16384;
        end
    endtask

    vec_t tbl[$];
    vec_t e;
    int lat;
    bit [7:0] rd;
    bit [2:0] r;
    bit we;
    bit [7:0] d;

    initial begin
        // Reset with a $2007 write request held: nothing may strobe
        seed = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_reg = 3'd7; cpu_wdata = 8'h5A;
        fill_mem();
        repeat (2) @(negedge clk);
        chk("rst_ack", int'(cpu_ack), 0);
        chk("rst_rdata", int'(cpu_rdata), 0);
        chk("rst_strobes", int'({vram_rden, vram_wren, pal_rden, pal_wren}), 0);
        cpu_req = 1'b0;
        reset_n = 1'b1;
        load(1'b0, 'h2000, 8'h11);
        load(1'b0, 'h2001, 8'h22);
        load(1'b0, 'h2002, 8'h33);
        load(1'b0, 'h2F00, 8'h5A);
        load(1'b0, 'h2100, 8'hC3);

        tbl.push_back(w6(8'h21));
        tbl.push_back(w6(8'h08));
        tbl.push_back(mk(1, 3'd7, 8'hAA, 0, 1, 0, 8'h00, 1, 'h2108, 8'hAA));
        tbl.push_back(w6(8'h20));
        tbl.push_back(w6(8'h00));
        tbl.push_back(mk(0, 3'd7, 8'h00, 0, 2, 1, 8'h00, 0, 0, 8'h00));
        tbl.push_back(mk(0, 3'd7, 8'h00, 0, 2, 1, 8'h11, 0, 0, 8'h00));
        tbl.push_back(mk(0, 3'd7, 8'h00, 0, 2, 1, 8'h22, 0, 0, 8'h00));
        tbl.push_back(w6(8'h3F));
        tbl.push_back(w6(8'h10));
        tbl.push_back(mk(1, 3'd7, 8'h2C, 0, 1, 0, 8'h00, 2, 'h10, 8'h2C));
        tbl.push_back(w6(8'h3F));
        tbl.push_back(w6(8'h11));
        tbl.push_back(mk(1, 3'd7, 8'hEF, 0, 1, 0, 8'h00, 2, 'h11, 8'hEF));
        tbl.push_back(w6(8'h3F));
        tbl.push_back(w6(8'h11));
        tbl.push_back(mk(0, 3'd7, 8'h00, 0, 3, 1, 8'h2F, 0, 0, 8'h00));
        tbl.push_back(w6(8'h3F));
        tbl.push_back(w6(8'h00));
        tbl.push_back(mk(0, 3'd7, 8'h00, 0, 3, 1, 8'h2C, 0, 0, 8'h00));
        tbl.push_back(w6(8'h20));
        tbl.push_back(w6(8'h05));
        tbl.push_back(mk(0, 3'd7, 8'h00, 0, 2, 1, 8'h5A, 0, 0, 8'h00));
        tbl.push_back(w6(8'h3F));
        tbl.push_back(w6(8'hE8));
        tbl.push_back(mk(1, 3'd7, 8'h77, 1, 1, 0, 8'h00, 2, 'h08, 8'h77));
        tbl.push_back(mk(1, 3'd7, 8'h55, 0, 1, 0, 8'h00, 1, 'h0008, 8'h55));
        tbl.push_back(w6(8'h3F));
        tbl.push_back(mk(0, 3'd2, 8'h00, 0, 1, 1, 8'h00, 0, 0, 8'h00));
        tbl.push_back(w6(8'h00));
        tbl.push_back(w6(8'h05));
        tbl.push_back(mk(1, 3'd7, 8'h66, 0, 1, 0, 8'h00, 1, 'h0005, 8'h66));
        tbl.push_back(mk(1, 3'd0, 8'hFF, 0, 1, 0, 8'h00, 0, 0, 8'h00));
        tbl.push_back(mk(0, 3'd6, 8'h00, 0, 1, 0, 8'h00, 0, 0, 8'h00));
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // A request arriving during a read wait is dropped without an ack
        run_vec(w6(8'h21), "drop_a");
        run_vec(w6(8'h00), "drop_b");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_reg = 3'd7;
        @(negedge clk);
        cpu_we = 1'b1; cpu_reg = 3'd6; cpu_wdata = 8'h3F;
        @(negedge clk);
        cpu_req = 1'b0;
        chk("drop_rd_ack", int'(cpu_ack), 1);
        @(negedge clk);
        chk("drop_no_ack", int'(cpu_ack), 0);
        run_vec(w6(8'h21), "drop_c");
        run_vec(w6(8'h40), "drop_d");
        run_vec(mk(1, 3'd7, 8'h99, 0, 1, 0, 8'h00, 1, 'h2140, 8'h99), "drop_wr");

        // Reset during VRD_WAIT: no ack, v/w/rdbuf cleared (rdbuf holds $C3 before)
        run_vec(w6(8'h20), "rmid_a");
        run_vec(w6(8'h00), "rmid_b");
        run_vec(w6(8'h15), "rmid_c");
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_reg = 3'd7;
        @(negedge clk);
        cpu_req = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("rmid_ack", int'(cpu_ack), 0);
        chk("rmid_rdata", int'(cpu_rdata), 0);
        chk("rmid_strobes", int'({vram_rden, vram_wren, pal_rden, pal_wren}), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rmid_ack_after", int'(cpu_ack), 0);
        run_vec(mk(1, 3'd7, 8'h44, 0, 1, 0, 8'h00, 1, 'h0000, 8'h44), "rmid_v0");
        run_vec(w6(8'h21), "rmid_d");
        run_vec(w6(8'h08), "rmid_e");
        run_vec(mk(1, 3'd7, 8'hAB, 0, 1, 0, 8'h00, 1, 'h2108, 8'hAB), "rmid_w0");
        run_vec(mk(0, 3'd7, 8'h00, 0, 2, 1, 8'h00, 0, 0, 8'h00), "rmid_rb0");

        // Random accesses against the model
        seed = 'h5C;
        do_reset();
        fill_mem();
        mv.delete(); mp.delete();
        m_v = 0; m_thi = 0; m_w = 0; m_rb = 0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin r = 3'd7; we = 1'($urandom_range(0, 1)); end
                4, 5, 6:    begin r = 3'd6; we = ($urandom_range(0, 9) != 0); end
                7:          begin r = 3'd2; we = 1'b0; end
                default:    begin r = 3'($urandom_range(0, 7)); we = 1'($urandom_range(0, 1)); end
            endcase
            d = 8'($urandom_range(0, 255));
            if (r == 3'd6 && $urandom_range(0, 3) == 0) d = 8'h3F;
            predict(we, r, d, 1'($urandom_range(0, 1)), e);
            run_vec(e, $sformatf("rnd%0d", n));
        end

        chk("one_strobe", multi_cnt, 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
